// File: rtl/tens_sec_counter.sv
// Tens-of-seconds down-counting digit for the irrigation stopwatch.
// Synchronises the borrow from the units stage, counts MAX_DIGIT..0 with wrap, drives one 7-seg digit.
module tens_sec_counter #(
  parameter int MAX_DIGIT   = 5,
  parameter int PRESET_VAL  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       P,
  input  logic       G,
  input  logic       A,
  input  logic       BORROW_IN,
  output logic       CLK_OUT,
  output logic       ZERO,
  output logic       RUNNING,
  output logic [6:0] SEG
);

  localparam logic [3:0] MAX_D    = 4'(MAX_DIGIT);
  localparam logic [3:0] PRESET_D = 4'(PRESET_VAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               digit_q, digit_d;
  logic                     clk_out_q, clk_out_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     edge_q;
  logic                     dec_pulse;
  logic                     zone_en;

  assign zone_en   = G | A;
  // Rising edge of the synchronised borrow: one pulse however long BORROW_IN stays high.
  assign dec_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      state_q   <= S_IDLE;
      digit_q   <= 4'd0;
      clk_out_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], BORROW_IN};
      edge_q    <= sync_q[SYNC_STAGES-1];
      state_q   <= state_d;
      digit_q   <= digit_d;
      clk_out_q <= clk_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    clk_out_d = 1'b0;
    if (P) begin
      // Load outranks any decrement pulse arriving on the same edge.
      digit_d = PRESET_D;
      state_d = zone_en ? S_RUN : S_PAUSE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (!zone_en) begin
            state_d = S_PAUSE;
          end else if (dec_pulse) begin
            if (digit_q == 4'd0) begin
              digit_d   = MAX_D;
              clk_out_d = 1'b1;
            end else begin
              digit_d = digit_q - 4'd1;
            end
          end
        end
        S_PAUSE: begin
          if (zone_en) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign CLK_OUT = clk_out_q;
  assign ZERO    = (digit_q == 4'd0);
  assign RUNNING = (state_q == S_RUN);

  always_comb begin
    SEG = 7'b0000000;
    case (digit_q)
      4'd0: SEG = 7'b1111110;
      4'd1: SEG = 7'b0110000;
      4'd2: SEG = 7'b1101101;
      4'd3: SEG = 7'b1111001;
      4'd4: SEG = 7'b0110011;
      4'd5: SEG = 7'b1011011;
      4'd6: SEG = 7'b1011111;
      4'd7: SEG = 7'b1110000;
      4'd8: SEG = 7'b1111111;
      4'd9: SEG = 7'b1111011;
      default: SEG = 7'b0000000;
    endcase
  end

endmodule
